// File: rtl/crc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc_pkg: CRC-16-CCITT constants, state encoding and bit-step helper.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package crc_pkg;

    localparam int              CRC_WIDTH = 16;
    localparam logic [15:0]     CRC_POLY  = 16'h1021;
    localparam logic [15:0]     CRC_INIT  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [CRC_WIDTH-1:0] crc_step(
        input logic [CRC_WIDTH-1:0] crc,
        input logic                 bit_in
    );
        logic fb;
        fb = crc[CRC_WIDTH-1] ^ bit_in;
        return {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc_lfsr: 16-bit serial CRC register with load-init and step-enable. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module crc_lfsr
    import crc_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 bit_in,
    output logic [CRC_WIDTH-1:0] crc
);

    // load beats step so a restart discards the bit presented with it
    always_ff @(posedge clk) begin
        if (reset) begin
            crc <= CRC_INIT;
        end else if (load) begin
            crc <= CRC_INIT;
        end else if (step) begin
            crc <= crc_step(crc, bit_in);
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_crc_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_crc_checker: framed MSB-first CRC-16-CCITT residue checker.   |
// | Optional macro CRC_CHECKER_ERR_COUNT_EN adds a saturating err_count. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module serial_crc_checker
    import crc_pkg::*;
#(
    parameter int PAYLOAD_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 init,
    input  logic                 data_in,
    output logic                 busy,
    output logic                 done,
    output logic                 crc_ok,
    output logic                 crc_err,
    output logic [CRC_WIDTH-1:0] crc_out
`ifdef CRC_CHECKER_ERR_COUNT_EN
    ,
    output logic [15:0]          err_count
`endif
);

    localparam int               CNT_W     = $clog2(PAYLOAD_BITS + 17);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(PAYLOAD_BITS + 15);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             final_bit;
    logic             residue_zero;

    assign busy         = (state == ST_DATA) || (state == ST_CHECK);
    assign accept       = enable && !init && busy;
    assign final_bit    = accept && (state == ST_CHECK) && (bit_cnt == LAST_BIT);
    // Verdict is taken from the value the LFSR is about to load
    assign residue_zero = (crc_step(crc_out, data_in) == '0);

    crc_lfsr u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .load   (init),
        .step   (accept),
        .bit_in (data_in),
        .crc    (crc_out)
    );

    always_comb begin
        state_next = state;
        if (init) begin
            state_next = ST_DATA;
        end else if (accept) begin
            if (state == ST_DATA && bit_cnt == LAST_DATA) begin
                state_next = ST_CHECK;
            end else if (final_bit) begin
                state_next = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            done    <= 1'b0;
            crc_ok  <= 1'b0;
            crc_err <= 1'b0;
        end else begin
            state <= state_next;
            if (init) begin
                bit_cnt <= '0;
                done    <= 1'b0;
                crc_ok  <= 1'b0;
                crc_err <= 1'b0;
            end else begin
                done <= final_bit;
                if (accept) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (final_bit) begin
                    crc_ok  <= residue_zero;
                    crc_err <= !residue_zero;
                end
            end
        end
    end

`ifdef CRC_CHECKER_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (final_bit && !residue_zero && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_crc_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_crc_checker: directed frames for serial_crc_checker.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_serial_crc_checker;

    localparam int          PB      = 72;
    localparam int          NBITS   = PB + 16;
    localparam logic [71:0] PAYLOAD = "123456789";
    localparam logic [15:0] GOOD    = 16'h29B1;

    logic        clk = 1'b0;
    logic        reset, enable, init, data_in;
    logic        busy, done, crc_ok, crc_err;
    logic [15:0] crc_out;
`ifdef CRC_CHECKER_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    serial_crc_checker #(.PAYLOAD_BITS(PB)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .init      (init),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .crc_out   (crc_out)
`ifdef CRC_CHECKER_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_bad    = 0;
    int done_cnt = 0;
    int exp_errs = 0;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    typedef struct {
        string       name;
        int          flip;
        logic [15:0] crc;
        bit          gaps;
        bit          exp_ok;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit gaps);
        if (gaps) begin
            int g;
            g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) begin
                enable  = 1'b0;
                data_in = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        enable  = 1'b1;
        data_in = b;
        @(negedge clk);
        enable  = 1'b0;
    endtask

    task automatic do_init();
        init    = 1'b1;
        enable  = 1'b1;
        data_in = 1'b1;
        @(negedge clk);
        init    = 1'b0;
        enable  = 1'b0;
    endtask

    task automatic send_frame(input int flip, input logic [15:0] crcv, input bit gaps,
                              input int nbits);
        logic [NBITS-1:0] fr;
        fr = {PAYLOAD, crcv};
        if (flip >= 0) fr[NBITS-1-flip] = ~fr[NBITS-1-flip];
        for (int i = 0; i < nbits; i++) send_bit(fr[NBITS-1-i], gaps);
    endtask

    initial begin
        int          d0;
        logic [15:0] held;

        vecs[0] = '{"good_cont",   -1, GOOD,     1'b0, 1'b1};
        vecs[1] = '{"flip_bit5",    5, GOOD,     1'b0, 1'b0};
        vecs[2] = '{"crc_29b0",    -1, 16'h29B0, 1'b0, 1'b0};
        vecs[3] = '{"good_gaps",   -1, GOOD,     1'b1, 1'b1};
        vecs[4] = '{"flip_bit70",  70, GOOD,     1'b1, 1'b0};
        vecs[5] = '{"crc_zero",    -1, 16'h0000, 1'b0, 1'b0};

        reset = 1'b1; enable = 1'b0; init = 1'b0; data_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy",  busy,    0);
        chk("rst_done",  done,    0);
        chk("rst_ok",    crc_ok,  0);
        chk("rst_err",   crc_err, 0);
        chk("rst_crc",   crc_out, 16'hFFFF);
`ifdef CRC_CHECKER_ERR_COUNT_EN
        chk("rst_errcnt", err_count, 0);
`endif

        // IDLE ignores bits until init
        send_frame(-1, GOOD, 1'b0, 8);
        chk("idle_crc",  crc_out, 16'hFFFF);
        chk("idle_busy", busy,    0);

        foreach (vecs[v]) begin
            do_init();
            chk({vecs[v].name, "_busy0"}, busy,    1);
            chk({vecs[v].name, "_init"},  crc_out, 16'hFFFF);
            d0 = done_cnt;
            send_frame(vecs[v].flip, vecs[v].crc, vecs[v].gaps, NBITS - 1);
            chk({vecs[v].name, "_busy1"}, busy, 1);
            chk({vecs[v].name, "_early"}, done, 0);
            begin
                logic [NBITS-1:0] fr;
                fr = {PAYLOAD, vecs[v].crc};
                send_bit(fr[0], vecs[v].gaps);
            end
            chk({vecs[v].name, "_done"},  done,    1);
            chk({vecs[v].name, "_ok"},    crc_ok,  vecs[v].exp_ok);
            chk({vecs[v].name, "_err"},   crc_err, !vecs[v].exp_ok);
            chk({vecs[v].name, "_busy2"}, busy,    0);
            chk({vecs[v].name, "_res0"},  crc_out == 16'h0000, vecs[v].exp_ok);
            if (!vecs[v].exp_ok) exp_errs++;
            held = crc_out;
            send_bit(1'b1, 1'b0);
            chk({vecs[v].name, "_pulse"}, done,    0);
            chk({vecs[v].name, "_hold"},  crc_ok,  vecs[v].exp_ok);
            chk({vecs[v].name, "_ign"},   crc_out, held);
            chk({vecs[v].name, "_ndone"}, done_cnt - d0, 1);
        end

`ifdef CRC_CHECKER_ERR_COUNT_EN
        chk("errcnt", err_count, exp_errs);
`endif

        // Restart mid-frame at bit 40, then a full good frame
        do_init();
        d0 = done_cnt;
        send_frame(-1, GOOD, 1'b0, 40);
        do_init();
        chk("restart_clr", crc_out, 16'hFFFF);
`ifdef CRC_CHECKER_ERR_COUNT_EN
        chk("errcnt_init", err_count, exp_errs);
`endif
        send_frame(-1, GOOD, 1'b0, NBITS);
        chk("restart_ok", crc_ok, 1);
        send_bit(1'b0, 1'b0);
        chk("restart_ndone", done_cnt - d0, 1);

        // init coincident with the final CRC bit wins
        do_init();
        d0 = done_cnt;
        send_frame(-1, GOOD, 1'b0, NBITS - 1);
        init = 1'b1; enable = 1'b1; data_in = GOOD[0];
        @(negedge clk);
        init = 1'b0; enable = 1'b0;
        chk("coll_done", done,    0);
        chk("coll_ok",   crc_ok,  0);
        chk("coll_busy", busy,    1);
        chk("coll_crc",  crc_out, 16'hFFFF);
        @(negedge clk);
        chk("coll_ndone", done_cnt - d0, 0);

        // reset at bit 60 aborts silently
        do_init();
        d0 = done_cnt;
        send_frame(-1, GOOD, 1'b0, 60);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy,    0);
        chk("abort_done", done,    0);
        chk("abort_ok",   crc_ok,  0);
        chk("abort_err",  crc_err, 0);
        chk("abort_crc",  crc_out, 16'hFFFF);
`ifdef CRC_CHECKER_ERR_COUNT_EN
        chk("abort_errcnt", err_count, 0);
`endif
        send_frame(-1, GOOD, 1'b0, 30);
        chk("abort_ndone", done_cnt - d0, 0);
        chk("abort_idle",  crc_out, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
